// File: rtl/branch_resolve_pkg.sv
// branch_resolve_pkg: opcodes, condition codes, flag indices and FSM states
// shared by the branch resolution unit.
package branch_resolve_pkg;

    localparam logic [2:0] OP_BRANCH = 3'b110;
    localparam logic [2:0] OP_JALR   = 3'b111;

    localparam int FLAG_O = 3;
    localparam int FLAG_S = 2;
    localparam int FLAG_Z = 1;
    localparam int FLAG_C = 0;

    localparam logic [3:0] CC_AL  = 4'd0;
    localparam logic [3:0] CC_Z   = 4'd1;
    localparam logic [3:0] CC_NZ  = 4'd2;
    localparam logic [3:0] CC_S   = 4'd3;
    localparam logic [3:0] CC_NS  = 4'd4;
    localparam logic [3:0] CC_C   = 4'd5;
    localparam logic [3:0] CC_NC  = 4'd6;
    localparam logic [3:0] CC_O   = 4'd7;
    localparam logic [3:0] CC_NO  = 4'd8;
    localparam logic [3:0] CC_POS = 4'd9;
    localparam logic [3:0] CC_GT  = 4'd10;
    localparam logic [3:0] CC_GE  = 4'd11;
    localparam logic [3:0] CC_LT  = 4'd12;
    localparam logic [3:0] CC_LE  = 4'd13;
    localparam logic [3:0] CC_AB  = 4'd14;
    localparam logic [3:0] CC_BE  = 4'd15;

    typedef enum logic {IDLE, FLUSH} state_t;

endpackage

// File: rtl/branch_resolve_cond.sv
// branch_cond: combinational condition-code evaluation against {O,S,Z,C}.
// Signed/unsigned compare codes 10..15 decode only with BRANCH_SIGNED_EN.
module branch_cond
    import branch_resolve_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] flags,
    output logic       taken
);

    logic o, s, z, c;

    assign o = flags[FLAG_O];
    assign s = flags[FLAG_S];
    assign z = flags[FLAG_Z];
    assign c = flags[FLAG_C];

    always_comb begin
        taken = 1'b0;
        case (cond)
            CC_AL:  taken = 1'b1;
            CC_Z:   taken = z;
            CC_NZ:  taken = !z;
            CC_S:   taken = s;
            CC_NS:  taken = !s;
            CC_C:   taken = c;
            CC_NC:  taken = !c;
            CC_O:   taken = o;
            CC_NO:  taken = !o;
            CC_POS: taken = !z && !s;
`ifdef BRANCH_SIGNED_EN
            CC_GT:  taken = !z && (s == o);
            CC_GE:  taken = (s == o);
            CC_LT:  taken = (s != o);
            CC_LE:  taken = z || (s != o);
            CC_AB:  taken = c && !z;
            CC_BE:  taken = !c || z;
`endif
            default: taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/branch_resolve.sv
// branch_resolve: execute-stage branch/jalr resolution with registered redirect,
// FLUSH_CYCLES-long flush FSM and resolution counters (BRANCH_SIGNED_EN optional).
module branch_resolve
    import branch_resolve_pkg::*;
#(
    parameter int FLUSH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        valid,
    input  logic [2:0]  op,
    input  logic [3:0]  cond,
    input  logic [3:0]  flags,
    input  logic [15:0] pc,
    input  logic [15:0] imm,
    input  logic [15:0] jalr_target,
    output logic        redirect,
    output logic [15:0] target,
    output logic        flush,
    output logic [15:0] branch_cnt,
    output logic [15:0] taken_cnt
);

    state_t     state, state_nx;
    logic [2:0] cnt, cnt_nx;
    logic       cond_taken, resolve, taken;

    branch_cond u_cond (
        .cond  (cond),
        .flags (flags),
        .taken (cond_taken)
    );

    assign resolve = valid && (op == OP_BRANCH || op == OP_JALR) && state == IDLE;
    assign taken   = resolve && (op == OP_JALR || cond_taken);
    assign flush   = state == FLUSH;

    // cnt holds the flush cycles still to go after the current one
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        if (state == IDLE) begin
            if (taken) begin
                state_nx = FLUSH;
                cnt_nx   = 3'(FLUSH_CYCLES - 1);
            end
        end else if (cnt == 3'd0) begin
            state_nx = IDLE;
        end else begin
            cnt_nx = cnt - 3'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= 3'd0;
            redirect   <= 1'b0;
            target     <= 16'h0000;
            branch_cnt <= 16'h0000;
            taken_cnt  <= 16'h0000;
        end else begin
            state      <= state_nx;
            cnt        <= cnt_nx;
            redirect   <= taken;
            if (taken)
                target <= (op == OP_JALR) ? jalr_target : pc + imm;
            branch_cnt <= branch_cnt + 16'(resolve);
            taken_cnt  <= taken_cnt + 16'(taken);
        end
    end

endmodule

// File: tb/tb_branch_resolve.sv
// tb_branch_resolve: directed and random checks of branch_resolve against a
// cycle-indexed reference model.
module tb_branch_resolve;

    localparam int F = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        valid = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [3:0]  cond = 4'd0;
    logic [3:0]  flags = 4'd0;
    logic [15:0] pc = 16'h0;
    logic [15:0] imm = 16'h0;
    logic [15:0] jalr_target = 16'h0;
    logic        redirect, flush;
    logic [15:0] target, branch_cnt, taken_cnt;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int free_at = 0;
    logic        m_redirect = 1'b0;
    logic [15:0] m_target = 16'h0;
    logic [15:0] m_bc = 16'h0;
    logic [15:0] m_tc = 16'h0;

    branch_resolve #(.FLUSH_CYCLES(F)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .valid       (valid),
        .op          (op),
        .cond        (cond),
        .flags       (flags),
        .pc          (pc),
        .imm         (imm),
        .jalr_target (jalr_target),
        .redirect    (redirect),
        .target      (target),
        .flush       (flush),
        .branch_cnt  (branch_cnt),
        .taken_cnt   (taken_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic ref_taken(input logic [3:0] cc, input logic [3:0] f);
        logic o, s, z, c;
        o = f[3];
        s = f[2];
        z = f[1];
        c = f[0];
        case (cc)
            4'd0:  return 1'b1;
            4'd1:  return z;
            4'd2:  return !z;
            4'd3:  return s;
            4'd4:  return !s;
            4'd5:  return c;
            4'd6:  return !c;
            4'd7:  return o;
            4'd8:  return !o;
            4'd9:  return !z && !s;
`ifdef BRANCH_SIGNED_EN
            4'd10: return !z && (s == o);
            4'd11: return s == o;
            4'd12: return s != o;
            4'd13: return z || (s != o);
            4'd14: return c && !z;
            4'd15: return !c || z;
`endif
            default: return 1'b0;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, "_redirect"}, 16'(redirect), 16'(m_redirect));
        chk({tag, "_flush"}, 16'(flush), 16'(cyc < free_at));
        chk({tag, "_target"}, target, m_target);
        chk({tag, "_branch_cnt"}, branch_cnt, m_bc);
        chk({tag, "_taken_cnt"}, taken_cnt, m_tc);
    endtask

    task automatic step(input logic v, input logic [2:0] o, input logic [3:0] cc,
                        input logic [3:0] f, input logic [15:0] p, input logic [15:0] i,
                        input logic [15:0] j);
        logic res, tk;
        valid = v;
        op = o;
        cond = cc;
        flags = f;
        pc = p;
        imm = i;
        jalr_target = j;
        res = v && (o == 3'b110 || o == 3'b111) && cyc >= free_at;
        tk = res && (o == 3'b111 || ref_taken(cc, f));
        @(posedge clk);
        #1;
        cyc++;
        m_redirect = tk;
        if (tk) begin
            m_target = (o == 3'b111) ? j : 16'(p + i);
            free_at = cyc + F;
        end
        m_bc = m_bc + 16'(res);
        m_tc = m_tc + 16'(tk);
        check_all("step");
    endtask

    task automatic idle();
        step(1'b0, 3'd0, 4'd0, 4'd0, 16'h0, 16'h0, 16'h0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        m_redirect = 1'b0;
        m_target = 16'h0;
        m_bc = 16'h0;
        m_tc = 16'h0;
        free_at = 0;
        check_all("rst");
        @(posedge clk);
        @(posedge clk);
        #1;
        check_all("rst_hold");
        rst_n = 1'b1;
    endtask

    initial begin
        do_reset();
        chk("reset_flush", 16'(flush), 16'h0);

        step(1'b1, 3'b110, 4'd1, 4'b0010, 16'h0010, 16'h0005, 16'h0);
        chk("r033_redirect", 16'(redirect), 16'h1);
        chk("r033_target", target, 16'h0015);
        chk("r033_taken_cnt", taken_cnt, 16'h1);
        idle();
        chk("r033_flush2", 16'(flush), 16'h1);
        chk("r033_redirect_pulse", 16'(redirect), 16'h0);
        idle();
        chk("r033_flush_end", 16'(flush), 16'h0);

        do_reset();
        step(1'b1, 3'b110, 4'd2, 4'b0010, 16'h0040, 16'h0008, 16'h0);
        chk("r034_redirect", 16'(redirect), 16'h0);
        chk("r034_flush", 16'(flush), 16'h0);
        chk("r034_branch_cnt", branch_cnt, 16'h1);
        chk("r034_taken_cnt", taken_cnt, 16'h0);

        step(1'b1, 3'b110, 4'd0, 4'b0000, 16'hFFFE, 16'h0004, 16'h0);
        chk("r035_target", target, 16'h0002);
        idle();
        idle();

        do_reset();
        step(1'b1, 3'b110, 4'd0, 4'b0000, 16'h0100, 16'h0010, 16'h0);
        step(1'b1, 3'b111, 4'd0, 4'b0000, 16'h0, 16'h0, 16'h5555);
        chk("r036_squash_cnt", branch_cnt, 16'h1);
        chk("r036_squash_redirect", 16'(redirect), 16'h0);
        step(1'b1, 3'b111, 4'd0, 4'b0000, 16'h0, 16'h0, 16'h5555);
        chk("r036_squash_cnt2", branch_cnt, 16'h1);
        step(1'b1, 3'b111, 4'd0, 4'b0000, 16'h0, 16'h0, 16'h1234);
        chk("r036_jalr_redirect", 16'(redirect), 16'h1);
        chk("r036_jalr_target", target, 16'h1234);

        do_reset();
        step(1'b1, 3'b110, 4'd12, 4'b0100, 16'h0200, 16'h0020, 16'h0);
`ifdef BRANCH_SIGNED_EN
        chk("r037_redirect", 16'(redirect), 16'h1);
`else
        chk("r037_redirect", 16'(redirect), 16'h0);
`endif
        chk("r037_branch_cnt", branch_cnt, 16'h1);
        idle();
        idle();

        do_reset();
        step(1'b1, 3'b110, 4'd0, 4'b0000, 16'h0300, 16'h0030, 16'h0);
        chk("r038_in_flush", 16'(flush), 16'h1);
        do_reset();
        chk("r038_flush", 16'(flush), 16'h0);
        chk("r038_branch_cnt", branch_cnt, 16'h0);
        chk("r038_taken_cnt", taken_cnt, 16'h0);
        step(1'b1, 3'b110, 4'd0, 4'b0000, 16'h0400, 16'h0002, 16'h0);
        chk("r038_redirect", 16'(redirect), 16'h1);
        chk("r038_target", target, 16'h0402);

        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 99) == 0)
                do_reset();
            step(1'($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 3) != 0) ? 3'(6 + $urandom_range(0, 1)) : 3'($urandom),
                 4'($urandom), 4'($urandom), 16'($urandom), 16'($urandom), 16'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/branch_resolve.md
BRANCH_RESOLVE -- requirements
Module: branch_resolve

Interface
REQ-001 SHALL have parameter FLUSH_CYCLES, default 2, giving the number of cycles flush is held after a redirect (legal range 1..7).
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-004 SHALL have port valid, input, 1 bit: the execute-stage instruction is real (not a bubble).
REQ-005 SHALL have port op, input, 3 bits: opcode, where 3'b110 is a conditional branch and 3'b111 is jalr.
REQ-006 SHALL have port cond, input, 4 bits: branch condition code.
REQ-007 SHALL have port flags, input, 4 bits: {O,S,Z,C}, taken from the ALU flags register.
REQ-008 SHALL have port pc, input, 16 bits: PC of the execute-stage instruction.
REQ-009 SHALL have port imm, input, 16 bits: sign-extended branch offset.
REQ-010 SHALL have port jalr_target, input, 16 bits: register-sourced jump address.
REQ-011 SHALL have port redirect, output, 1 bit: one-cycle fetch redirect pulse.
REQ-012 SHALL have port target, output, 16 bits: redirect address, valid while redirect=1.
REQ-013 SHALL have port flush, output, 1 bit: squash younger pipeline stages.
REQ-014 SHALL have port branch_cnt, output, 16 bits: count of resolved branches and jalrs.
REQ-015 SHALL have port taken_cnt, output, 16 bits: count of taken branches and jalrs.

Function
REQ-016 SHALL resolve an instruction only when valid=1, op is 3'b110 or 3'b111, and the FSM is in IDLE; all other cycles SHALL resolve nothing.
REQ-017 SHALL use the cond encoding 0:always, 1:Z, 2:!Z, 3:S, 4:!S, 5:C, 6:!C, 7:O, 8:!O, 9:!Z&!S.
REQ-018 SHALL treat jalr as always taken, with target=jalr_target.
REQ-019 SHALL compute the branch target as pc+imm, truncated to 16 bits (wraps at 16'hFFFF).
REQ-020 SHALL produce registered outputs: a taken resolution in cycle N gives redirect=1 and target in cycle N+1, for exactly one cycle.
REQ-021 SHALL leave redirect=0 and flush=0 for a not-taken branch; target SHALL hold its previous value.
REQ-022 SHALL implement an FSM with states IDLE and FLUSH; a taken resolution SHALL move IDLE->FLUSH.
REQ-023 SHALL assert flush from the redirect cycle for exactly FLUSH_CYCLES cycles, then return to IDLE.
REQ-024 SHALL ignore valid branches while in FLUSH (they are squashed); no redirect and no count SHALL result.
REQ-025 SHALL resolve a branch presented in the first IDLE cycle after FLUSH normally (back-to-back taken branches are legal).
REQ-026 SHALL increment branch_cnt on every resolution and taken_cnt on every taken resolution, both wrapping modulo 2^16; taken_cnt SHALL never exceed branch_cnt except across a wrap.

Reset
REQ-027 SHALL, while rst_n=0, force FSM=IDLE, redirect=0, flush=0, target=0, branch_cnt=0 and taken_cnt=0, independent of clk.
REQ-028 SHALL abort a flush sequence immediately when reset is asserted mid-FLUSH; the first valid branch after release SHALL resolve normally.

Configuration
REQ-029 SHALL, with BRANCH_SIGNED_EN defined, additionally decode cond 10:gt (!Z & S==O), 11:ge (S==O), 12:lt (S!=O), 13:le (Z | S!=O), 14:above (C & !Z), 15:below-or-equal (!C | Z).
REQ-030 SHALL, with BRANCH_SIGNED_EN undefined, treat cond 10..15 as never taken, while still counting them in branch_cnt.

Structure
REQ-031 SHALL place the opcode constants (OP_BRANCH, OP_JALR), the cond code constants, the flag bit indices (O=3, S=2, Z=1, C=0) and the FSM state typedef in the shared CPU package.
REQ-032 SHALL put condition evaluation in one combinational sub-module, branch_cond (inputs cond and flags, output taken); the FSM, target register and counters SHALL stay in branch_resolve.

Verification
REQ-033 SHALL test: cond=1, flags=4'b0010, pc=16'h0010, imm=16'h0005 -> next cycle redirect=1, target=16'h0015, flush=1 for 2 cycles, taken_cnt=1.
REQ-034 SHALL test: cond=2, flags=4'b0010 -> redirect=0, flush=0, branch_cnt=1, taken_cnt=0.
REQ-035 SHALL test: pc=16'hFFFE, imm=16'h0004, cond=0 -> target=16'h0002 (wrap).
REQ-036 SHALL test: a taken branch followed by a valid jalr during FLUSH -> jalr ignored, branch_cnt=1; a jalr with jalr_target=16'h1234 in the first IDLE cycle -> redirect, target=16'h1234.
REQ-037 SHALL test: cond=12, flags=4'b0100 -> taken with BRANCH_SIGNED_EN defined; not taken without it, branch_cnt still incremented.
REQ-038 SHALL test: rst_n pulled low in the first FLUSH cycle -> flush=0, counters=0 immediately; the next taken branch after release redirects normally.
